// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the 5-stage pipeline (master) and branch_predictor (slave).
// Carries the IF lookup, the ID-stage resolution, the redirect and the statistics outputs.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_i;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;

    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_pred_taken_i;
    logic [XLEN-1:0] upd_pred_target_i;

    logic            mispredict_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [31:0]     stat_branches_o;
    logic [31:0]     stat_mispred_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               stat_branches_o, stat_mispred_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               stat_branches_o, stat_mispred_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: zero-latency IF lookup, ID-stage update/redirect.
// Define BP_STATS_EN to enable the resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(2 ** (CTR_W - 1) - 1);

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of 2, at least 2");
    end
    if (CTR_W < 1 || CTR_W > 4) begin : g_bad_ctr_w
        $error("branch_predictor: CTR_W must be in 1..4");
    end
    if ($bits(bp.pc_i) != XLEN) begin : g_bad_xlen
        $error("branch_predictor: interface XLEN differs from module XLEN");
    end

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             misp_raw;
    logic [XLEN-1:0]  redirect_raw;
    logic             unused_pc_bits;

    assign lk_idx = bp.pc_i[IDX_W+1:2];
    assign lk_tag = bp.pc_i[XLEN-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign up_idx = bp.upd_pc_i[IDX_W+1:2];
    assign up_tag = bp.upd_pc_i[XLEN-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign unused_pc_bits = ^bp.pc_i[1:0];

    assign misp_raw = bp.upd_valid_i &&
                      ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
                       (bp.upd_taken_i && (bp.upd_target_i != bp.upd_pred_target_i)));
    assign redirect_raw = bp.upd_taken_i ? bp.upd_target_i : bp.upd_pc_i + XLEN'(4);

    always_comb begin
        bp.pred_taken_o  = 1'b0;
        bp.pred_target_o = '0;
        bp.mispredict_o  = 1'b0;
        bp.redirect_pc_o = '0;
        if (!rst_i) begin
            bp.pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
            bp.pred_target_o = lk_hit ? target_q[lk_idx] : '0;
            bp.mispredict_o  = misp_raw;
            bp.redirect_pc_o = redirect_raw;
        end
    end

    // A not-taken miss is deliberately not allocated so cold branches stay out of the table.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.upd_valid_i) begin
            if (up_hit) begin
                if (bp.upd_taken_i) begin
                    target_d[up_idx] = bp.upd_target_i;
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
                    end
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (bp.upd_taken_i) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.upd_target_i;
                ctr_d[up_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (bp.upd_valid_i && stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (misp_raw && stat_mispred_q != 32'hFFFF_FFFF) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign bp.stat_branches_o = stat_branches_q;
    assign bp.stat_mispred_o  = stat_mispred_q;
`else
    assign bp.stat_branches_o = '0;
    assign bp.stat_mispred_o  = '0;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- Replaces the static "resolve in ID, flush on taken" scheme.
- IF stage: looks up the current PC in a direct-mapped branch target buffer (BTB) with per-entry saturating counters. It supplies a predicted next PC that same cycle.
- ID stage: branch resolution updates the tables and raises mispredict with the correct redirect PC.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entry count; power of 2, minimum 2.
- CTR_W, 2, saturating counter width; range 1..4.
- IDX_W, log2(ENTRIES), derived localparam, not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pc_i  in  XLEN  IF-stage fetch PC
- pred_taken_o  out  1  prediction: taken
- pred_target_o  out  XLEN  predicted target; valid when pred_taken_o=1
- upd_valid_i  in  1  a conditional branch is resolving in ID this cycle
- upd_pc_i  in  XLEN  PC of the resolving branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  XLEN  actual taken target
- upd_pred_taken_i  in  1  prediction that was carried with this branch through IFID
- upd_pred_target_i  in  XLEN  predicted target carried through IFID
- mispredict_o  out  1  flush IFID and redirect the PC
- redirect_pc_o  out  XLEN  correct next PC
- stat_branches_o  out  32  resolved-branch count (see Optional Feature)
- stat_mispred_o  out  32  misprediction count (see Optional Feature)

Behaviour:
- Per-entry state: valid (1), tag (XLEN-IDX_W-2), target (XLEN), ctr (CTR_W).
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Reset (rst_i high at a posedge):
  - All valid bits clear.
  - All ctr = 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
  - Target and tag contents are don't-care.
  - While rst_i is high: pred_taken_o=0, pred_target_o=0, mispredict_o=0, redirect_pc_o=0.
  - Reset asserted mid-operation discards any update presented in that cycle.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==tag(pc_i).
  - pred_taken_o = hit && ctr[idx][CTR_W-1].
  - pred_target_o = hit ? target[idx] : 0.
- Update (registered at posedge when upd_valid_i=1), indexed by upd_pc_i:
  - Hit, taken: ctr increments, saturating at 2^CTR_W-1. Target is overwritten with upd_target_i.
  - Hit, not taken: ctr decrements, saturating at 0. Target is unchanged.
  - Miss, taken: allocate the entry (possibly evicting another tag). valid=1, tag, target=upd_target_i, ctr=2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no state change.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. There is no write-through bypass.
- Mispredict (combinational from upd_* inputs):
  - mispredict_o = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i)).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 4. Addition is modulo 2^XLEN (wraps at the top of memory).
  - redirect_pc_o is driven whenever not in reset, independent of mispredict_o.
- upd_valid_i=0: the upd_* inputs are ignored and mispredict_o=0.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_branches_o increments on every accepted update (upd_valid_i and not rst_i).
  - stat_mispred_o increments when mispredict_o=1 in the same cycle.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, then pc_i=0x40 -> pred_taken_o=0, pred_target_o=0; all 16 indices miss.
- Update pc=0x40, taken, target=0x10 (pred 0/0); next cycle pc_i=0x40 -> mispredict_o=1 and redirect_pc_o=0x10 during the update cycle; afterwards pred_taken_o=1, pred_target_o=0x10.
- Counter saturation at pc=0x40:
  - Four taken updates, then one not-taken -> still predicts taken (ctr 3->2).
  - A second not-taken -> pred_taken_o=0; a third leaves ctr=0.
- Aliasing:
  - Entry allocated at 0x40; lookup 0x80 (same index with ENTRIES=16 is 0x40+64) -> miss, pred_taken_o=0.
  - Taken update at 0x80 -> evicts; 0x40 now misses.
- Same-cycle update and lookup of 0x40 (not taken, ctr=2) -> pred_taken_o=1 that cycle, 0 the next cycle.
- Not-taken update, pc=0xFFFFFFFC, pred 1 -> mispredict_o=1, redirect_pc_o=0x00000000. With BP_STATS_EN, after 5 updates including 2 mispredicts -> stat_branches_o=5, stat_mispred_o=2.
